// File: rtl/adc_sar_sequencer.sv
// SAR conversion sequencer: sample/convert cycles, 2^k averaging with rounding, and a
// valid/ready result port with sticky overflow.
// Optional feature macro: ADC_SEQ_RAW_CODE_EN adds a per-conversion raw code tap
// (raw_code_out / raw_valid_out) that pulses in ACCUM and has no backpressure.
module adc_sar_sequencer #(
  parameter int unsigned RES_BITS     = 12,
  parameter int unsigned AVG_LOG2_MAX = 4,
  parameter int unsigned SAMPLE_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in,
  input  logic                    continuous_in,
  input  logic [2:0]              avg_log2_in,
  input  logic [SAMPLE_CNT_W-1:0] sample_cycles_in,
  input  logic                    comparator_in,
  output logic                    sample_out,
  output logic                    sample_out_n,
  output logic                    enable_loop_out,
  output logic [RES_BITS-1:0]     pswitch_out,
  output logic [RES_BITS-1:0]     nswitch_out,
  output logic                    busy_out,
  output logic [RES_BITS-1:0]     result_out,
  output logic                    result_valid_out,
  input  logic                    result_ready_in,
  output logic                    overflow_out
`ifdef ADC_SEQ_RAW_CODE_EN
  ,
  output logic [RES_BITS-1:0]     raw_code_out,
  output logic                    raw_valid_out
`endif
);

  localparam int unsigned AccW = RES_BITS + AVG_LOG2_MAX;
  localparam int unsigned CntW = AVG_LOG2_MAX + 1;
  localparam int unsigned BitW = $clog2(RES_BITS);

  typedef enum logic [2:0] {StIdle, StSample, StConvert, StAccum, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic [SAMPLE_CNT_W-1:0] s_q, s_d;
  logic [SAMPLE_CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [RES_BITS-1:0]     code_q, code_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [RES_BITS-1:0]     result_q, result_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;

  logic [RES_BITS-1:0] trial;
  logic [RES_BITS-1:0] keep_mask;
  logic [RES_BITS-1:0] hi_mask;
  logic [AccW-1:0]     acc_rnd;
  logic [CntW-1:0]     count_inc;
  logic [CntW-1:0]     count_target;
  logic [2:0]          k_clamped;
  logic                load_result;

  // Trial-word decode, rounding and clamp helpers.
  always_comb begin
    trial        = RES_BITS'(1) << bit_q;
    keep_mask    = ~(trial - RES_BITS'(1));   // trial bit and everything above it
    hi_mask      = keep_mask & ~trial;        // already-decided bits only
    acc_rnd      = acc_q + ((k_q != 3'd0) ? (AccW'(1) << (k_q - 3'd1)) : '0);
    count_inc    = count_q + CntW'(1);
    count_target = CntW'(1) << k_q;
    k_clamped    = (32'(avg_log2_in) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_log2_in;
  end

  // Next-state logic for the sequencer FSM, datapath and result handshake.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    samp_cnt_d  = samp_cnt_q;
    bit_d       = bit_q;
    code_d      = code_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
    load_result = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          k_d        = k_clamped;
          s_d        = sample_cycles_in;
          samp_cnt_d = sample_cycles_in;
          acc_d      = '0;
          count_d    = '0;
          state_d    = StSample;
        end
      end
      StSample: begin
        if (samp_cnt_q == '0) begin
          bit_d   = BitW'(RES_BITS - 1);
          state_d = StConvert;
        end else begin
          samp_cnt_d = samp_cnt_q - SAMPLE_CNT_W'(1);
        end
      end
      StConvert: begin
        code_d[bit_q] = comparator_in;
        if (bit_q == '0) begin
          state_d = StAccum;
        end else begin
          bit_d = bit_q - BitW'(1);
        end
      end
      StAccum: begin
        acc_d   = acc_q + AccW'(code_q);
        count_d = count_inc;
        if (count_inc == count_target) begin
          state_d = StDone;
        end else begin
          samp_cnt_d = s_q;
          state_d    = StSample;
        end
      end
      StDone: begin
        load_result = 1'b1;
        if (continuous_in) begin
          acc_d      = '0;
          count_d    = '0;
          samp_cnt_d = s_q;
          state_d    = StSample;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accept drops valid unless a new result lands on the same edge.
    if (valid_q && result_ready_in) begin
      valid_d = 1'b0;
    end
    if (load_result) begin
      result_d = RES_BITS'(acc_rnd >> k_q);
      valid_d  = 1'b1;
      if (valid_q && !result_ready_in) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset; a reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      s_q        <= '0;
      samp_cnt_q <= '0;
      bit_q      <= '0;
      code_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      s_q        <= s_d;
      samp_cnt_q <= samp_cnt_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    sample_out       = (state_q == StSample);
    sample_out_n     = ~sample_out;
    enable_loop_out  = (state_q == StConvert);
    pswitch_out      = enable_loop_out ? ((code_q & hi_mask) | trial) : '0;
    nswitch_out      = enable_loop_out ? (~pswitch_out & keep_mask) : '0;
    busy_out         = (state_q != StIdle);
    result_out       = result_q;
    result_valid_out = valid_q;
    overflow_out     = overflow_q;
  end

`ifdef ADC_SEQ_RAW_CODE_EN
  // Raw tap: code_q is complete for the whole ACCUM cycle.
  assign raw_code_out  = code_q;
  assign raw_valid_out = (state_q == StAccum);
`endif

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Scoreboard bench for adc_sar_sequencer (RES_BITS=12, AVG_LOG2_MAX=4).
// An ideal comparator resolves per-conversion input values from a table.
module tb_adc_sar_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        continuous_in;
  logic [2:0]  avg_log2_in;
  logic [3:0]  sample_cycles_in;
  logic        comparator_in;
  logic        sample_out;
  logic        sample_out_n;
  logic        enable_loop_out;
  logic [11:0] pswitch_out;
  logic [11:0] nswitch_out;
  logic        busy_out;
  logic [11:0] result_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic        overflow_out;
`ifdef ADC_SEQ_RAW_CODE_EN
  logic [11:0] raw_code_out;
  logic        raw_valid_out;
  logic [11:0] raw_seen[$];
`endif

  adc_sar_sequencer #(
    .RES_BITS(12),
    .AVG_LOG2_MAX(4),
    .SAMPLE_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .continuous_in(continuous_in),
    .avg_log2_in(avg_log2_in),
    .sample_cycles_in(sample_cycles_in),
    .comparator_in(comparator_in),
    .sample_out(sample_out),
    .sample_out_n(sample_out_n),
    .enable_loop_out(enable_loop_out),
    .pswitch_out(pswitch_out),
    .nswitch_out(nswitch_out),
    .busy_out(busy_out),
    .result_out(result_out),
    .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in),
    .overflow_out(overflow_out)
`ifdef ADC_SEQ_RAW_CODE_EN
    ,
    .raw_code_out(raw_code_out),
    .raw_valid_out(raw_valid_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  // Analog input per conversion; idx advances when a conversion ends.
  logic [11:0] vins[32];
  int          idx = 0;
  logic        prev_en = 1'b0;
  logic [11:0] cur_vin;

  always_comb cur_vin = vins[idx[4:0]];
  assign comparator_in = enable_loop_out && (pswitch_out <= cur_vin);

  always @(negedge clk) begin
    if (prev_en && !enable_loop_out) idx = idx + 1;
    prev_en = enable_loop_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor: every transfer pops one expected code.
  always @(negedge clk) begin
    if (!rst && result_valid_out && result_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%0h expected none", result_out);
      end else begin
        check("result", {20'd0, result_out}, {20'd0, exp_q.pop_front()});
      end
    end
  end

`ifdef ADC_SEQ_RAW_CODE_EN
  always @(negedge clk) begin
    if (!rst && raw_valid_out) raw_seen.push_back(raw_code_out);
  end
`endif

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample"}, {31'd0, sample_out}, 32'd0);
    check({tag, "_sample_n"}, {31'd0, sample_out_n}, 32'd1);
    check({tag, "_enable_loop"}, {31'd0, enable_loop_out}, 32'd0);
    check({tag, "_pswitch"}, {20'd0, pswitch_out}, 32'd0);
    check({tag, "_nswitch"}, {20'd0, nswitch_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    check({tag, "_result"}, {20'd0, result_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, result_valid_out}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow_out}, 32'd0);
  endtask

  // Start one run and measure clocks from the start edge to valid.
  task automatic run_measure(input logic [2:0] k, input logic [3:0] s, input int exp_lat,
                             input string name);
    int n;
    idx = 0;
    avg_log2_in = k;
    sample_cycles_in = s;
    start_in = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
    n = 0;
    while (n < 4000 && !result_valid_out) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
  endtask

  // Wait (bounded) until enable_loop_out equals lvl, sampled 1 after posedge.
  task automatic wait_en(input logic lvl, input string name);
    int n;
    n = 0;
    while (n < 500 && enable_loop_out !== lvl) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got enable=%0b expected %0b", name, enable_loop_out, lvl);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_in = 1'b0;
    continuous_in = 1'b0;
    avg_log2_in = 3'd0;
    sample_cycles_in = 4'd0;
    result_ready_in = 1'b1;
    for (int i = 0; i < 32; i++) vins[i] = 12'h000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // k=0, S=4: latency 4 + 13 + 1 = 18, then back to idle.
    vins[0] = 12'hA5C;
    exp_q.push_back(12'hA5C);
    run_measure(3'd0, 4'd3, 18, "k0");
    check("k0_idle", {31'd0, busy_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // k=2: (404 + 2) >> 2 = 101; latency 16 + 52 + 1 = 69.
    vins[0] = 12'd100; vins[1] = 12'd101; vins[2] = 12'd101; vins[3] = 12'd102;
    exp_q.push_back(12'd101);
`ifdef ADC_SEQ_RAW_CODE_EN
    raw_seen.delete();
`endif
    run_measure(3'd2, 4'd3, 69, "k2");
`ifdef ADC_SEQ_RAW_CODE_EN
    check("raw_count", raw_seen.size(), 4);
    if (raw_seen.size() == 4) begin
      check("raw0", {20'd0, raw_seen[0]}, 32'd100);
      check("raw1", {20'd0, raw_seen[1]}, 32'd101);
      check("raw2", {20'd0, raw_seen[2]}, 32'd101);
      check("raw3", {20'd0, raw_seen[3]}, 32'd102);
    end
`endif
    repeat (3) @(posedge clk);
    #1;

    // k=1: (4094 + 4095 + 1) >> 1 = 4095; latency 8 + 26 + 1 = 35.
    vins[0] = 12'd4094; vins[1] = 12'd4095;
    exp_q.push_back(12'd4095);
    run_measure(3'd1, 4'd3, 35, "k1");
    repeat (3) @(posedge clk);
    #1;

    // k=7 clamps to 4: 16 conversions, latency 64 + 208 + 1 = 273.
    for (int i = 0; i < 32; i++) vins[i] = 12'h123;
    exp_q.push_back(12'h123);
    run_measure(3'd7, 4'd3, 273, "clamp");
    check("clamp_conversions", idx, 16);
    repeat (3) @(posedge clk);
    #1;

    // Continuous mode with backpressure: overwrite sets sticky overflow.
    vins[0] = 12'h111; vins[1] = 12'h222; vins[2] = 12'h333; vins[3] = 12'h444;
    result_ready_in = 1'b0;
    continuous_in = 1'b1;
    run_measure(3'd0, 4'd0, 15, "cont");
    check("cont_r1", {20'd0, result_out}, 32'h111);
    check("cont_ovf0", {31'd0, overflow_out}, 32'd0);
    wait_en(1'b1, "cont_c2_rise");
    wait_en(1'b0, "cont_c2_fall");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("cont_r2", {20'd0, result_out}, 32'h222);
    check("cont_ovf1", {31'd0, overflow_out}, 32'd1);
    check("cont_valid2", {31'd0, result_valid_out}, 32'd1);
    // Accept on the same edge as the third load.
    exp_q.push_back(12'h222);
    wait_en(1'b1, "cont_c3_rise");
    wait_en(1'b0, "cont_c3_fall");
    @(posedge clk);
    #1 result_ready_in = 1'b1;
    @(posedge clk);
    #1 result_ready_in = 1'b0;
    continuous_in = 1'b0;
    check("cont_valid3", {31'd0, result_valid_out}, 32'd1);
    check("cont_r3", {20'd0, result_out}, 32'h333);
    check("cont_ovf_kept", {31'd0, overflow_out}, 32'd1);
    // Clearing continuous stops after the conversion in progress.
    n = 0;
    while (n < 500 && busy_out) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cont_stopped", {31'd0, busy_out}, 32'd0);
    check("cont_r4", {20'd0, result_out}, 32'h444);
    check("cont_ovf_sticky", {31'd0, overflow_out}, 32'd1);
    exp_q.push_back(12'h444);
    result_ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("cont_drained", {31'd0, result_valid_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-CONVERT aborts with no result.
    vins[0] = 12'h5A3;
    idx = 0;
    avg_log2_in = 3'd0;
    sample_cycles_in = 4'd3;
    start_in = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
    check("abort_sample", {31'd0, sample_out}, 32'd1);
    check("abort_sample_n", {31'd0, sample_out_n}, 32'd0);
    check("abort_busy", {31'd0, busy_out}, 32'd1);
    wait_en(1'b1, "abort_convert");
    check("step11_p", {20'd0, pswitch_out}, 32'h800);
    check("step11_n", {20'd0, nswitch_out}, 32'h000);
    @(posedge clk);
    #1;
    check("step10_p", {20'd0, pswitch_out}, 32'h400);
    check("step10_n", {20'd0, nswitch_out}, 32'h800);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_valid", {31'd0, result_valid_out}, 32'd0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
